// File: rtl/hist_eq_sequencer.sv
// Multi-frame ping-pong sequencer for the histogram-equalisation datapath.
// Overlaps input of frame k+1 with output of frame k; per-phase watchdog aborts stalls.
module hist_eq_sequencer #(
    parameter int unsigned CDF_W       = 20,
    parameter int unsigned PIXEL_COUNT = 65536,
    parameter int unsigned FRAME_W     = 8,
    parameter int unsigned TIMEOUT     = 2**20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] num_frames,
    input  logic               bypass,
    output logic               input_start,
    input  logic               input_done,
    input  logic               cdf_valid,
    input  logic [CDF_W-1:0]   cdf_min_in,
    output logic               input_base_offset,
    output logic               output_start,
    input  logic               output_done,
    output logic               output_base_offset,
    output logic [CDF_W-1:0]   cdf_min_out,
    output logic [CDF_W-1:0]   divisor,
    output logic [FRAME_W-1:0] frame_count,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_IN_RUN, S_OVERLAP, S_OUT_DRAIN, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] in_left_q, in_left_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic [CDF_W-1:0]   cdf_hold_q, cdf_hold_d;
    logic [CDF_W-1:0]   cdf_min_out_q, cdf_min_out_d;
    logic [CDF_W-1:0]   divisor_q, divisor_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic bypass_q, bypass_d;
    logic cdf_seen_q, cdf_seen_d;
    logic in_seen_q, in_seen_d;
    logic out_seen_q, out_seen_d;
    logic in_bank_q, in_bank_d;
    logic out_bank_q, out_bank_d;
    logic input_start_q, input_start_d;
    logic output_start_q, output_start_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic             handoff;
    logic             wd_clr;
    logic [CDF_W-1:0] cdf_eff;

    always_comb begin
        state_d        = state_q;
        in_left_d      = in_left_q;
        frame_count_d  = frame_count_q;
        cdf_hold_d     = cdf_hold_q;
        cdf_min_out_d  = cdf_min_out_q;
        divisor_d      = divisor_q;
        bypass_d       = bypass_q;
        cdf_seen_d     = cdf_seen_q;
        in_seen_d      = in_seen_q;
        out_seen_d     = out_seen_q;
        in_bank_d      = in_bank_q;
        out_bank_d     = out_bank_q;
        error_d        = error_q;
        input_start_d  = 1'b0;
        output_start_d = 1'b0;
        done_d         = 1'b0;
        handoff        = 1'b0;
        wd_clr         = 1'b0;
        wd_d           = '0;
        cdf_eff        = cdf_seen_q ? cdf_hold_q : '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_IN_RUN;
                    in_left_d     = (num_frames == '0) ? '0 : num_frames - FRAME_W'(1);
                    bypass_d      = bypass;
                    frame_count_d = '0;
                    error_d       = 1'b0;
                    cdf_seen_d    = 1'b0;
                    in_seen_d     = 1'b0;
                    out_seen_d    = 1'b0;
                    in_bank_d     = 1'b0;
                    input_start_d = 1'b1;
                end
            end
            S_IN_RUN: begin
                if (in_seen_q) begin
                    handoff = 1'b1;
                end else if (input_done) begin
                    in_seen_d = 1'b1;
                    wd_clr    = 1'b1;
                end
            end
            S_OVERLAP: begin
                if (in_seen_q && out_seen_q) begin
                    handoff = 1'b1;
                end else begin
                    if (input_done && !in_seen_q) begin
                        in_seen_d = 1'b1;
                        wd_clr    = 1'b1;
                    end
                    if (output_done && !out_seen_q) begin
                        out_seen_d    = 1'b1;
                        frame_count_d = frame_count_q + FRAME_W'(1);
                        wd_clr        = 1'b1;
                    end
                end
            end
            S_OUT_DRAIN: begin
                if (output_done) begin
                    frame_count_d = frame_count_q + FRAME_W'(1);
                    state_d       = S_FINISH;
                    done_d        = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if ((state_q == S_IN_RUN || state_q == S_OVERLAP) && cdf_valid) begin
            cdf_hold_d = cdf_min_in;
            cdf_seen_d = 1'b1;
        end

        // Handoff is deferred one clock after the done flags latch, giving the
        // two-cycle input_done -> output_start latency.
        if (handoff) begin
            if (!cdf_seen_q) error_d = 1'b1;
            if (bypass_q) begin
                cdf_min_out_d = '0;
                divisor_d     = CDF_W'(PIXEL_COUNT);
            end else if (cdf_eff >= CDF_W'(PIXEL_COUNT)) begin
                error_d       = 1'b1;
                cdf_min_out_d = '0;
                divisor_d     = CDF_W'(1);
            end else begin
                cdf_min_out_d = cdf_eff;
                divisor_d     = CDF_W'(PIXEL_COUNT) - cdf_eff;
            end
            in_seen_d      = 1'b0;
            out_seen_d     = 1'b0;
            out_bank_d     = in_bank_q;
            output_start_d = 1'b1;
            if (in_left_q != '0) begin
                in_left_d     = in_left_q - FRAME_W'(1);
                in_bank_d     = ~in_bank_q;
                input_start_d = 1'b1;
                cdf_seen_d    = 1'b0;
                state_d       = S_OVERLAP;
            end else begin
                state_d = S_OUT_DRAIN;
            end
        end

        if ((state_q == S_IN_RUN || state_q == S_OVERLAP || state_q == S_OUT_DRAIN) &&
            state_d == state_q && !handoff && !wd_clr && wd_q == WD_W'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            state_d = S_FINISH;
            done_d  = 1'b1;
        end

        if (state_d != state_q || handoff || wd_clr || state_q == S_IDLE)
            wd_d = '0;
        else
            wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            in_left_q      <= '0;
            frame_count_q  <= '0;
            cdf_hold_q     <= '0;
            cdf_min_out_q  <= '0;
            divisor_q      <= '0;
            wd_q           <= '0;
            bypass_q       <= 1'b0;
            cdf_seen_q     <= 1'b0;
            in_seen_q      <= 1'b0;
            out_seen_q     <= 1'b0;
            in_bank_q      <= 1'b0;
            out_bank_q     <= 1'b0;
            input_start_q  <= 1'b0;
            output_start_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_left_q      <= in_left_d;
            frame_count_q  <= frame_count_d;
            cdf_hold_q     <= cdf_hold_d;
            cdf_min_out_q  <= cdf_min_out_d;
            divisor_q      <= divisor_d;
            wd_q           <= wd_d;
            bypass_q       <= bypass_d;
            cdf_seen_q     <= cdf_seen_d;
            in_seen_q      <= in_seen_d;
            out_seen_q     <= out_seen_d;
            in_bank_q      <= in_bank_d;
            out_bank_q     <= out_bank_d;
            input_start_q  <= input_start_d;
            output_start_q <= output_start_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign input_start        = input_start_q;
    assign input_base_offset  = in_bank_q;
    assign output_start       = output_start_q;
    assign output_base_offset = out_bank_q;
    assign cdf_min_out        = cdf_min_out_q;
    assign divisor            = divisor_q;
    assign frame_count        = frame_count_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = done_q;
    assign error              = error_q;

endmodule
